// File: rtl/sdram_rd_arb_if.sv
// Client/controller signal bundle for the SDRAM read arbiter.
// The arbiter uses the slave view; clients and the controller model use the master view.
interface sdram_rd_arb_if #(
   parameter int unsigned XWIDTH = 20,
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned NPORTS = 2
);
   logic [NPORTS-1:0]        c_req;
   logic [NPORTS*XWIDTH-1:0] c_addr;
   logic [NPORTS*4-1:0]      c_len;
   logic [NPORTS-1:0]        c_ack;
   logic [DWIDTH-1:0]        c_rdata;
   logic [NPORTS-1:0]        c_rvalid;
   logic [XWIDTH-1:0]        rd_addr;
   logic [3:0]               rd_len;
   logic                     rd_req;
   logic                     rd_ack;
   logic [DWIDTH-1:0]        rd_data;
   logic                     rd_rdy;
   logic                     busy;
   logic                     err;

   modport slave (
      input  c_req, c_addr, c_len, rd_ack, rd_data, rd_rdy,
      output c_ack, c_rdata, c_rvalid, rd_addr, rd_len, rd_req, busy, err
   );

   modport master (
      output c_req, c_addr, c_len, rd_ack, rd_data, rd_rdy,
      input  c_ack, c_rdata, c_rvalid, rd_addr, rd_len, rd_req, busy, err
   );
endinterface

// File: rtl/sdram_rd_arb.sv
// Round-robin arbiter sharing one SDRAM read port among NPORTS burst-read clients.
// One burst in flight at a time; returned words are steered to the granted client.
module sdram_rd_arb #(
   parameter int unsigned XWIDTH = 20,
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned NPORTS = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   sdram_rd_arb_if.slave    arb_io
);
   localparam int unsigned PW = $clog2(NPORTS);
   localparam int unsigned CW = 5;
   localparam int unsigned LW = 4;

   generate
      if (NPORTS < 2 || NPORTS > 4) begin : g_bad_nports
         $error("sdram_rd_arb: NPORTS must be in 2..4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, REQ, DATA} state_e;

   state_e              state_q, state_d;
   logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]       grant_q, grant_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [XWIDTH-1:0]   rd_addr_q, rd_addr_d;
   logic [LW-1:0]       rd_len_q, rd_len_d;
   logic                rd_req_q, rd_req_d;
   logic [NPORTS-1:0]   c_ack_q, c_ack_d;
   logic [NPORTS-1:0]   c_rvalid_q, c_rvalid_d;
   logic [DWIDTH-1:0]   c_rdata_q, c_rdata_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;

   logic                found_c;
   logic [PW-1:0]       pick_c;
   logic [PW-1:0]       cand_c;
   int unsigned         idx_c;
   logic                beat_c;
   logic [PW-1:0]       rr_next_c;
   logic [LW-1:0]       len_sel_c;

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         cnt_q      <= '0;
         rd_addr_q  <= '0;
         rd_len_q   <= '0;
         rd_req_q   <= 1'b0;
         c_ack_q    <= '0;
         c_rvalid_q <= '0;
         c_rdata_q  <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         cnt_q      <= cnt_d;
         rd_addr_q  <= rd_addr_d;
         rd_len_q   <= rd_len_d;
         rd_req_q   <= rd_req_d;
         c_ack_q    <= c_ack_d;
         c_rvalid_q <= c_rvalid_d;
         c_rdata_q  <= c_rdata_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   // Next state, arbitration and beat accounting
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      cnt_d      = cnt_q;
      rd_addr_d  = rd_addr_q;
      rd_len_d   = rd_len_q;
      rd_req_d   = rd_req_q;
      c_ack_d    = '0;
      c_rvalid_d = '0;
      c_rdata_d  = c_rdata_q;
      err_d      = err_q;
      found_c    = 1'b0;
      pick_c     = '0;
      cand_c     = '0;
      idx_c      = 0;
      len_sel_c  = '0;
      rr_next_c  = (grant_q == PW'(NPORTS - 1)) ? '0 : grant_q + PW'(1);

      // First requester at or after rr_ptr, wrapping modulo NPORTS
      for (int unsigned i = 0; i < NPORTS; i++) begin
         idx_c = 32'(rr_ptr_q) + i;
         if (idx_c >= NPORTS) idx_c = idx_c - NPORTS;
         cand_c = PW'(idx_c);
         if (!found_c && arb_io.c_req[cand_c]) begin
            found_c = 1'b1;
            pick_c  = cand_c;
         end
      end

      // Beats only count while a burst is open; stray ones flag an error
      beat_c = arb_io.rd_rdy && (state_q != IDLE) && (cnt_q != '0);
      if (beat_c) begin
         cnt_d               = cnt_q - CW'(1);
         c_rdata_d           = arb_io.rd_data;
         c_rvalid_d[grant_q] = 1'b1;
      end else if (arb_io.rd_rdy) begin
         err_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (found_c) begin
               len_sel_c       = arb_io.c_len[32'(pick_c)*LW +: LW];
               grant_d         = pick_c;
               rd_addr_d       = arb_io.c_addr[32'(pick_c)*XWIDTH +: XWIDTH];
               rd_len_d        = len_sel_c;
               c_ack_d[pick_c] = 1'b1;
               rd_req_d        = 1'b1;
               cnt_d           = CW'(len_sel_c) + CW'(1);
               state_d         = REQ;
            end
         end
         REQ: begin
            if (arb_io.rd_ack) begin
               rd_req_d = 1'b0;
               state_d  = (cnt_d == '0) ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_d == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && state_d == IDLE) rr_ptr_d = rr_next_c;
      busy_d = (state_d != IDLE);
   end

   assign arb_io.c_ack    = c_ack_q;
   assign arb_io.c_rvalid = c_rvalid_q;
   assign arb_io.c_rdata  = c_rdata_q;
   assign arb_io.rd_addr  = rd_addr_q;
   assign arb_io.rd_len   = rd_len_q;
   assign arb_io.rd_req   = rd_req_q;
   assign arb_io.busy     = busy_q;
   assign arb_io.err      = err_q;
endmodule

// File: tb/tb_sdram_rd_arb.sv
// Directed bench for sdram_rd_arb (four clients); the bench plays both the
// clients and the SDRAM controller and checks every response against hand-worked values.
module tb_sdram_rd_arb;
   localparam int unsigned XW = 20;
   localparam int unsigned DW = 16;
   localparam int unsigned NP = 4;

   logic clk = 1'b0;
   logic reset_n;
   int   checks    = 0;
   int   failures  = 0;
   int   rv_cnt    = 0;
   int   rdreq_cnt = 0;

   always #5 clk = ~clk;

   sdram_rd_arb_if #(.XWIDTH(XW), .DWIDTH(DW), .NPORTS(NP)) arb_if ();

   sdram_rd_arb #(.XWIDTH(XW), .DWIDTH(DW), .NPORTS(NP)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .arb_io  (arb_if)
   );

   // Count returned words and cycles with rd_req high
   always @(negedge clk) begin
      if (|arb_if.c_rvalid) rv_cnt++;
      if (arb_if.rd_req) rdreq_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_rd_req"},   32'(arb_if.rd_req),   32'd0);
      check_eq({tag, "_c_ack"},    32'(arb_if.c_ack),    32'd0);
      check_eq({tag, "_c_rvalid"}, 32'(arb_if.c_rvalid), 32'd0);
      check_eq({tag, "_busy"},     32'(arb_if.busy),     32'd0);
      check_eq({tag, "_err"},      32'(arb_if.err),      32'd0);
      check_eq({tag, "_rd_addr"},  32'(arb_if.rd_addr),  32'd0);
      check_eq({tag, "_rd_len"},   32'(arb_if.rd_len),   32'd0);
      check_eq({tag, "_c_rdata"},  32'(arb_if.c_rdata),  32'd0);
   endtask

   task automatic drive_req(input int cl, input logic [XW-1:0] addr, input logic [3:0] len);
      arb_if.c_req[cl]            = 1'b1;
      arb_if.c_addr[cl*XW +: XW]  = addr;
      arb_if.c_len[cl*4 +: 4]     = len;
   endtask

   // Wait (bounded) for a grant, then check who got it and what was latched
   task automatic wait_ack(input string tag, input logic [NP-1:0] exp_ack,
                           input logic [XW-1:0] exp_addr, input logic [3:0] exp_len);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (|arb_if.c_ack) break;
      end
      check_eq({tag, "_ack"},     32'(arb_if.c_ack),   32'(exp_ack));
      check_eq({tag, "_rd_addr"}, 32'(arb_if.rd_addr), 32'(exp_addr));
      check_eq({tag, "_rd_len"},  32'(arb_if.rd_len),  32'(exp_len));
      check_eq({tag, "_busy"},    32'(arb_if.busy),    32'd1);
      check_eq({tag, "_rd_req"},  32'(arb_if.rd_req),  32'd1);
   endtask

   // Controller model: ack after ack_dly edges, then stream nbeats words
   task automatic serve(input string tag, input int ack_dly, input int nbeats,
                        input logic [DW-1:0] base, input logic [NP-1:0] exp_rv);
      repeat (ack_dly) @(posedge clk);
      #1 arb_if.rd_ack = 1'b1;
      tick();
      arb_if.rd_ack = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         arb_if.rd_rdy  = 1'b1;
         arb_if.rd_data = base + DW'(i);
         tick();
         check_eq({tag, "_rvalid"}, 32'(arb_if.c_rvalid), 32'(exp_rv));
         check_eq({tag, "_rdata"},  32'(arb_if.c_rdata),  32'(base + DW'(i)));
      end
      arb_if.rd_rdy = 1'b0;
      check_eq({tag, "_idle"}, 32'(arb_if.busy), 32'd0);
      tick();
      check_eq({tag, "_rv_off"}, 32'(arb_if.c_rvalid), 32'd0);
   endtask

   initial begin
      reset_n        = 1'b0;
      arb_if.c_req   = '0;
      arb_if.c_addr  = '0;
      arb_if.c_len   = '0;
      arb_if.rd_ack  = 1'b0;
      arb_if.rd_data = '0;
      arb_if.rd_rdy  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("rst");
      reset_n = 1'b1;
      tick();

      // Single burst, client 0, ack two cycles late, four words
      rdreq_cnt = 0;
      rv_cnt    = 0;
      drive_req(0, 20'h00100, 4'd3);
      wait_ack("t1", 4'b0001, 20'h00100, 4'd3);
      arb_if.c_req[0] = 1'b0;
      serve("t1", 2, 4, 16'h00A0, 4'b0001);
      check_eq("t1_rdreq_cycles", 32'(rdreq_cnt), 32'd3);
      check_eq("t1_rv_total",     32'(rv_cnt),    32'd4);

      // rr_ptr=1: lone client 3 wins, and afterwards client 0 outranks client 3
      drive_req(3, 20'h33000, 4'd1);
      wait_ack("t3", 4'b1000, 20'h33000, 4'd1);
      arb_if.c_req[3] = 1'b0;
      serve("t3", 1, 2, 16'h3000, 4'b1000);
      drive_req(0, 20'h00200, 4'd0);
      drive_req(3, 20'h33333, 4'd0);
      wait_ack("t3_rr", 4'b0001, 20'h00200, 4'd0);
      arb_if.c_req[0] = 1'b0;
      serve("t3_rr", 1, 1, 16'h0200, 4'b0001);
      wait_ack("t3_c3", 4'b1000, 20'h33333, 4'd0);
      arb_if.c_req[3] = 1'b0;
      serve("t3_c3", 1, 1, 16'h0333, 4'b1000);

      // Sixteen-beat burst, then one stray word
      rv_cnt = 0;
      drive_req(1, 20'h01000, 4'd15);
      wait_ack("t4", 4'b0010, 20'h01000, 4'd15);
      arb_if.c_req[1] = 1'b0;
      serve("t4", 1, 16, 16'hB000, 4'b0010);
      check_eq("t4_rv_total", 32'(rv_cnt), 32'd16);
      check_eq("t4_err_pre", 32'(arb_if.err), 32'd0);
      arb_if.rd_rdy  = 1'b1;
      arb_if.rd_data = 16'hDEAD;
      tick();
      arb_if.rd_rdy = 1'b0;
      check_eq("t4_stray_rv",  32'(arb_if.c_rvalid), 32'd0);
      check_eq("t4_stray_err", 32'(arb_if.err),      32'd1);
      tick();
      check_eq("t4_rv_total2", 32'(rv_cnt), 32'd16);

      // rd_ack and the only beat on the same edge
      drive_req(2, 20'h02000, 4'd0);
      wait_ack("t5", 4'b0100, 20'h02000, 4'd0);
      arb_if.c_req[2] = 1'b0;
      tick();
      arb_if.rd_ack  = 1'b1;
      arb_if.rd_rdy  = 1'b1;
      arb_if.rd_data = 16'h55AA;
      tick();
      arb_if.rd_ack = 1'b0;
      arb_if.rd_rdy = 1'b0;
      check_eq("t5_rvalid", 32'(arb_if.c_rvalid), 32'b0100);
      check_eq("t5_rdata",  32'(arb_if.c_rdata),  32'h55AA);
      check_eq("t5_idle",   32'(arb_if.busy),     32'd0);
      check_eq("t5_rd_req", 32'(arb_if.rd_req),   32'd0);
      tick();
      check_eq("t5_rv_off",     32'(arb_if.c_rvalid), 32'd0);
      check_eq("t5_err_sticky", 32'(arb_if.err),      32'd1);

      // Reset after two of four beats
      drive_req(0, 20'h04000, 4'd3);
      wait_ack("t6", 4'b0001, 20'h04000, 4'd3);
      arb_if.c_req[0] = 1'b0;
      tick();
      arb_if.rd_ack = 1'b1;
      tick();
      arb_if.rd_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         arb_if.rd_rdy  = 1'b1;
         arb_if.rd_data = 16'h4000 + 16'(i);
         tick();
         check_eq("t6_rvalid", 32'(arb_if.c_rvalid), 32'b0001);
      end
      arb_if.rd_data = 16'h4002;
      #2 reset_n = 1'b0;
      rv_cnt = 0;
      #1;
      check_all_zero("t6_async_rst");
      tick();
      tick();
      arb_if.rd_rdy = 1'b0;
      reset_n       = 1'b1;
      tick();
      check_eq("t6_no_rv_after_rst", 32'(rv_cnt), 32'd0);
      arb_if.rd_rdy  = 1'b1;
      arb_if.rd_data = 16'hBEEF;
      tick();
      arb_if.rd_rdy = 1'b0;
      check_eq("t6_post_rst_err", 32'(arb_if.err),      32'd1);
      check_eq("t6_post_rst_rv",  32'(arb_if.c_rvalid), 32'd0);
      drive_req(1, 20'h05000, 4'd0);
      wait_ack("t6_next", 4'b0010, 20'h05000, 4'd0);
      arb_if.c_req[1] = 1'b0;
      serve("t6_next", 1, 1, 16'h5000, 4'b0010);

      // Fresh reset, then clients 0 and 1 both requesting continuously
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      drive_req(0, 20'h06000, 4'd0);
      drive_req(1, 20'h07000, 4'd0);
      for (int g = 0; g < 4; g++) begin
         if (g % 2 == 0) begin
            wait_ack("t2_c0", 4'b0001, 20'h06000, 4'd0);
            if (g == 3) arb_if.c_req = '0;
            serve("t2_c0", 1, 1, 16'h6000 + 16'(g), 4'b0001);
         end else begin
            wait_ack("t2_c1", 4'b0010, 20'h07000, 4'd0);
            if (g == 3) arb_if.c_req = '0;
            serve("t2_c1", 1, 1, 16'h7000 + 16'(g), 4'b0010);
         end
      end
      tick();
      check_eq("t2_final_busy", 32'(arb_if.busy), 32'd0);
      check_eq("t2_final_err",  32'(arb_if.err),  32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sdram_rd_arb.md
SDRAM_RD_ARB -- requirements
Module: sdram_rd_arb

Interface
REQ-001 Parameter XWIDTH, default 20, word address width (row+bank+col), matches the SDRAM controller read address.
REQ-002 Parameter DWIDTH, default 16, data word width.
REQ-003 Parameter NPORTS, default 2, number of read clients; legal range 2..4; other values SHALL raise an elaboration error.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  reset; asynchronous assert, active-low.
REQ-006 c_req  in  NPORTS  per-client read request, level, held until matching c_ack.
REQ-007 c_addr  in  NPORTS*XWIDTH  per-client start address; client i at bits [i*XWIDTH +: XWIDTH].
REQ-008 c_len  in  NPORTS*4  per-client burst length minus one; client i at bits [i*4 +: 4].
REQ-009 c_ack  out  NPORTS  one-cycle pulse: request of client i latched.
REQ-010 c_rdata  out  DWIDTH  returned read word, shared by all clients.
REQ-011 c_rvalid  out  NPORTS  one-hot pulse: c_rdata valid for client i.
REQ-012 rd_addr  out  XWIDTH  to controller: latched address.
REQ-013 rd_len  out  4  to controller: latched length.
REQ-014 rd_req  out  1  to controller: read request, level.
REQ-015 rd_ack  in  1  from controller: request accepted, one-cycle pulse.
REQ-016 rd_data  in  DWIDTH  from controller: read word.
REQ-017 rd_rdy  in  1  from controller: rd_data valid.
REQ-018 busy  out  1  high whenever state is not IDLE.
REQ-019 err  out  1  sticky: rd_rdy seen while no beats outstanding.

Function
REQ-020 States SHALL be IDLE, REQ, DATA; all outputs SHALL be registered.
REQ-021 IDLE: if any c_req bit is set, grant the first requesting client at or after index rr_ptr (modulo NPORTS); latch its c_addr/c_len into rd_addr/rd_len, record grant index, pulse its c_ack, set rd_req, load beat counter = c_len+1 (5 bits), go to REQ.
REQ-022 IDLE with no c_req SHALL hold all outputs and remain in IDLE.
REQ-023 REQ: rd_req SHALL stay high until rd_ack is sampled high; on that edge rd_req SHALL clear and state SHALL go to DATA.
REQ-024 rd_rdy in REQ or DATA SHALL be counted: the counter decrements, c_rdata <= rd_data, and c_rvalid[grant] pulses on the next cycle (latency 1).
REQ-025 DATA: when the counter decrements from 1 to 0, state SHALL return to IDLE and rr_ptr SHALL become (grant+1) modulo NPORTS.
REQ-026 Arbitration SHALL occur only in IDLE; minimum one IDLE cycle between bursts.
REQ-027 rd_rdy arriving with counter 0, or in IDLE, SHALL be dropped (no c_rvalid) and SHALL set err; err clears only on reset.
REQ-028 If rd_ack and the final rd_rdy coincide in REQ, both SHALL take effect and state SHALL go directly to IDLE.
REQ-029 c_len = 15 SHALL give 16 beats; the counter SHALL not wrap.
REQ-030 c_req dropped before c_ack is not a legal stimulus; c_req changes after c_ack SHALL not affect the burst in flight.
REQ-031 At most one burst SHALL be outstanding; c_ack SHALL never pulse while busy.

Reset
REQ-032 With reset_n low, state SHALL be IDLE, rr_ptr = 0, counter = 0, and rd_req, c_ack, c_rvalid, busy, and err SHALL all be 0.
REQ-033 With reset_n low, rd_addr, rd_len, and c_rdata SHALL be 0.
REQ-034 Reset mid-burst SHALL abandon the burst without any further c_rvalid.
REQ-035 After reset, the first rd_rdy without a new grant SHALL set err.

Verification
REQ-036 Client 0 req addr=0x00100 len=3; controller acks after 2 cycles, gives 4 rd_rdy with data 0xA0..0xA3 -> c_ack[0] one pulse; rd_req high 3 cycles; c_rvalid[0] four pulses with 0xA0..0xA3, each one cycle after rd_rdy; IDLE after last beat.
REQ-037 Clients 0 and 1 both requesting continuously, len=0 -> grants alternate 0,1,0,1; neither client granted twice in a row.
REQ-038 NPORTS=4, only client 3 requests, rr_ptr=1 -> client 3 granted; rr_ptr becomes 0.
REQ-039 len=15 -> exactly 16 c_rvalid pulses, then IDLE; 17th rd_rdy sets err with no c_rvalid.
REQ-040 Same-cycle rd_ack and final rd_rdy in REQ (len=0) -> one c_rvalid, state IDLE next cycle.
REQ-041 reset_n pulsed low after 2 of 4 beats -> all outputs 0 asynchronously; no further c_rvalid; the next request is granted normally.
